// File: rtl/dmem_block_responder.sv
// Block-granular data memory answering data-cache refill and write-back requests
// over a busywait handshake. Optional macro DMEM_RESET_CLEAR_EN zeroes the store on reset.
module dmem_block_responder #(
    parameter int LATENCY = 5,
    parameter int NBLOCKS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        op_write;
    logic [5:0]  addr_q;
    logic [31:0] data_q;
    logic        access;
    logic [5:0]  blk;
    logic [31:0] mem [NBLOCKS];

    // Out-of-range block addresses fold back onto the store.
    function automatic logic [5:0] wrap(input logic [5:0] a);
        return 6'(32'(a) % NBLOCKS);
    endfunction

    assign blk = wrap(addr_q);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busywait   = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (read || write) begin
                    busywait   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            // DONE ignores read/write so a request still held high is not re-served.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= 4'd0;
            op_write <= 1'b0;
            addr_q   <= 6'd0;
            data_q   <= 32'd0;
            readdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (read || write) begin
                        op_write <= write;
                        addr_q   <= address;
                        data_q   <= writedata;
                        cnt      <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    if (access && !op_write) readdata <= mem[blk];
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NBLOCKS; i++) mem[i] <= 32'd0;
        end else if (access && op_write) begin
            mem[blk] <= data_q;
        end
    end
`else
    // NOTE: the store has no reset so it maps onto plain RAM; reset only blocks the pending write.
    always_ff @(posedge clock) begin
        if (!reset && access && op_write) mem[blk] <= data_q;
    end
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Self-checking bench for dmem_block_responder: directed scenarios plus randomized
// transactions against an array model of the block store.
module tb_dmem_block_responder;

    localparam int LATENCY = 5;
    localparam int NBLOCKS = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;

    int passed = 0;
    int total  = 0;

    logic [31:0] model [NBLOCKS];
    logic [31:0] exp_rd;

    dmem_block_responder #(.LATENCY(LATENCY), .NBLOCKS(NBLOCKS)) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic model_reset();
        exp_rd = 32'd0;
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < NBLOCKS; i++) model[i] = 32'd0;
`endif
    endtask

    // One full transaction; starts in the cycle after the next edge, ends in DONE
    // with the request released. mode: 0 quiet, 1 random noise in BUSY, 2 addr=7/data=0 in BUSY.
    task automatic transact(input logic rd, input logic wr, input logic [5:0] a,
                            input logic [31:0] d, input int mode);
        int n;
        int b;
        @(posedge clock); #1;
        read = rd; write = wr; address = a; writedata = d;
        #1;
        check("busy_on_request", 32'(busywait), 32'd1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (!busywait) break;
            n++;
            if (mode == 1) begin
                address = 6'($urandom); writedata = $urandom;
                read = 1'($urandom); write = 1'($urandom);
            end else if (mode == 2) begin
                address = 6'd7; writedata = 32'd0;
            end
        end
        check("busy_cycles", 32'(n), 32'(LATENCY));
        b = int'(a) % NBLOCKS;
        if (wr) model[b] = d;
        else    exp_rd = model[b];
        check("readdata_done", readdata, exp_rd);
        check("done_busy_low", 32'(busywait), 32'd0);
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NBLOCKS; i++) model[i] = 'x;
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_readdata", readdata, 32'd0);
        check("reset_busywait", 32'(busywait), 32'd0);

        // Read of block 3 with read held through DONE, then nothing re-starts.
        transact(1'b1, 1'b0, 6'd3, 32'd0, 0);
        @(posedge clock); #1;
        check("idle_after_done", 32'(busywait), 32'd0);

        // Write then read back.
        transact(1'b0, 1'b1, 6'd10, 32'hDEADBEEF, 0);
        transact(1'b1, 1'b0, 6'd10, 32'd0, 0);
        check("byte0", 32'(readdata[7:0]), 32'h000000EF);

        // Write-back followed immediately by refill.
        transact(1'b0, 1'b1, 6'd37, 32'h37373737, 0);
        transact(1'b0, 1'b1, 6'd5, 32'h11223344, 0);
        transact(1'b1, 1'b0, 6'd37, 32'd0, 0);
        transact(1'b1, 1'b0, 6'd5, 32'd0, 0);

        // Inputs moving during BUSY are ignored.
        transact(1'b0, 1'b1, 6'd7, 32'h77777777, 0);
        transact(1'b0, 1'b1, 6'd2, 32'hA5A5A5A5, 2);
        transact(1'b1, 1'b0, 6'd2, 32'd0, 0);
        transact(1'b1, 1'b0, 6'd7, 32'd0, 0);

        // Reset two cycles into a write aborts it.
        transact(1'b0, 1'b1, 6'd9, 32'h12345678, 0);
        @(posedge clock); #1;
        write = 1'b1; address = 6'd9; writedata = 32'hCAFEF00D;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1; write = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        check("abort_busywait", 32'(busywait), 32'd0);
        check("abort_readdata", readdata, 32'd0);
        transact(1'b1, 1'b0, 6'd9, 32'd0, 0);

        // Simultaneous read and write behaves as a write.
        transact(1'b1, 1'b1, 6'd12, 32'h0BADF00D, 0);
        transact(1'b1, 1'b0, 6'd12, 32'd0, 0);

        // Randomized traffic over a few blocks with noise during BUSY.
        for (int t = 0; t < 24; t++) begin
            int op;
            op = int'($urandom_range(0, 2));
            transact(op != 1, op != 0, 6'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
